endec_axis_driver: RTL
======================

ENDEC_AXIS_DRIVER -- requirements
Module: endec_axis_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 16'hFFFF, max cycles waiting for any result beat before abort.
REQ-002 sys_clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_start  in  1  one-cycle request to run one frame; sampled only in IDLE.
REQ-005 i_config  in  64  config word: [26:0] gen poly flat, [27] code rate, [35:28] prev encoder state, [63:36] zero.
REQ-006 i_payload  in  512  [127:0] encoder frame, [511:128] decoder frame.
REQ-007 m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  64/1/1  AXIS master toward endec_interface slave port.
REQ-008 m_axis_tready  in  1  sink ready.
REQ-009 s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  64/1/1  AXIS slave from endec_interface master port.
REQ-010 s_axis_tready  out  1  driver ready.
REQ-011 o_result  out  512  [383:0] encoder output, [511:384] decoded data.
REQ-012 o_done / o_busy / o_err_tlast / o_err_timeout  out  1 each  frame-complete pulse, activity, framing error, timeout error.

Function
REQ-013 SHALL implement states IDLE, SEND_CFG, SEND_DATA, RX_RESULT, DONE.
REQ-014 IDLE: i_start=1 -> latch i_config and i_payload into internal registers, clear both error flags, go SEND_CFG; o_busy=1 in every state except IDLE.
REQ-015 SEND_CFG: one beat, tdata=latched config, tvalid=1, tlast=1; on tvalid&tready go SEND_DATA next cycle.
REQ-016 SEND_DATA: 8 beats, beat k (k=0..7) tdata=payload[64k+63:64k]; tlast=1 only on k=7; 3-bit tx counter increments per handshake; after beat 7 handshake go RX_RESULT.
REQ-017 Master SHALL hold tdata/tlast stable and tvalid=1 until handshake; tvalid SHALL not depend combinationally on tready.
REQ-018 Minimum one idle cycle (tvalid=0) between config beat and data beat 0, matching sink CONF->RX_DATA turnaround.
REQ-019 RX_RESULT: s_axis_tready=1; beat k stored to o_result[64k+63:64k] on s_axis_tvalid&s_axis_tready; 3-bit rx counter.
REQ-020 tlast on beat k<7: set o_err_tlast, end frame, go DONE; remaining result bits keep prior contents.
REQ-021 beat 7 without tlast: set o_err_tlast, go DONE; beat 7 with tlast: go DONE, no error.
REQ-022 Watchdog counter cleared on every s_axis handshake and on entering RX_RESULT; reaching TIMEOUT_CYCLES sets o_err_timeout, drops s_axis_tready, goes DONE.
REQ-023 Timeout SHALL not be armed in SEND_CFG/SEND_DATA (sink backpressure unbounded).
REQ-024 DONE: o_done=1 for exactly one cycle, s_axis_tready=0, return IDLE; o_result and error flags hold until next accepted i_start.
REQ-025 i_start while o_busy=1 SHALL be ignored, no effect on latched data.
REQ-026 s_axis_tready SHALL be 0 outside RX_RESULT; s_axis_tvalid beats outside RX_RESULT are not consumed.
REQ-027 Latency with tready always 1 and result beats back-to-back: i_start to first m_axis_tvalid = 1 cycle; o_done 1 cycle after final result handshake.

Reset
REQ-028 rst=1 at edge: state=IDLE, counters=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, o_result=0, o_done=0, o_busy=0, both error flags=0.
REQ-029 rst mid-frame SHALL abort immediately with values of REQ-028 on next cycle; no partial beat retained.

Verification
REQ-030 Nominal: config=36'h0_5_B_6D_F4F, payload=incrementing bytes, sink tready=1, source returns 8 beats 64'hA0..A7 with tlast on 8th -> 1+8 master beats correct, tlast on beats 1 and 9, o_result beats match, o_done pulse, no errors.
REQ-031 Backpressure: m_axis_tready toggles 1-0-0-1 random -> each beat held stable until accepted, 9 beats total, order unchanged.
REQ-032 Early tlast on result beat 3 -> o_err_tlast=1, o_done on next cycle, o_result[511:256]=0 from reset.
REQ-033 No result beats, TIMEOUT_CYCLES=16 -> o_err_timeout=1 after 16 cycles in RX_RESULT, o_done pulse, return IDLE.
REQ-034 rst asserted during data beat 4, then new i_start -> all outputs zero after reset, fresh frame starts with config beat.
REQ-035 i_start pulsed during SEND_DATA with different payload -> ignored; transmitted beats match first payload.

Source files
------------

// File: rtl/endec_axis_driver_if.sv
// endec_axis_driver_if: one AXI-stream channel (data, valid, last, ready)
interface endec_axis_driver_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/endec_axis_driver.sv
// endec_axis_driver: sends one config beat plus 8 payload beats, then collects 8 result beats
module endec_axis_driver #(
  parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [63:0]         i_config,
  input  logic [511:0]        i_payload,
  endec_axis_driver_if.master m_axis,
  endec_axis_driver_if.slave  s_axis,
  output logic [511:0]        o_result,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_err_tlast,
  output logic                o_err_timeout
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CFG  = 3'd1;
  localparam logic [2:0] SEND_DATA = 3'd2;
  localparam logic [2:0] RX_RESULT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  logic [2:0]   state;
  logic [63:0]  cfg;
  logic [511:0] payload;
  logic [2:0]   tx_cnt;
  logic [2:0]   rx_cnt;
  logic [15:0]  wdog;
  logic         gap;
  logic         data_beat;
  // Outputs derive only from registered state, so tvalid never depends on tready
  always_comb begin
    data_beat     = state == SEND_DATA && !gap;
    m_axis.tvalid = state == SEND_CFG || data_beat;
    m_axis.tlast  = state == SEND_CFG || (data_beat && tx_cnt == 3'd7);
    m_axis.tdata  = state == SEND_CFG ? cfg : data_beat ? payload[{tx_cnt, 6'd0} +: 64] : 64'd0;
    s_axis.tready = state == RX_RESULT;
    o_done        = state == DONE;
    o_busy        = state != IDLE;
  end
  // Frame sequencer: gap gives the sink one idle cycle between config and data beat 0
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg           <= 64'd0;
      payload       <= 512'd0;
      tx_cnt        <= 3'd0;
      rx_cnt        <= 3'd0;
      wdog          <= 16'd0;
      gap           <= 1'b0;
      o_result      <= 512'd0;
      o_err_tlast   <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          cfg           <= i_config;
          payload       <= i_payload;
          tx_cnt        <= 3'd0;
          rx_cnt        <= 3'd0;
          o_err_tlast   <= 1'b0;
          o_err_timeout <= 1'b0;
          state         <= SEND_CFG;
        end
        SEND_CFG: if (m_axis.tready) begin
          gap   <= 1'b1;
          state <= SEND_DATA;
        end
        SEND_DATA: if (gap) gap <= 1'b0;
        else if (m_axis.tready) begin
          tx_cnt <= tx_cnt + 3'd1;
          if (&tx_cnt) begin
            wdog  <= 16'd0;
            state <= RX_RESULT;
          end
        end
        RX_RESULT: if (s_axis.tvalid) begin
          o_result[{rx_cnt, 6'd0} +: 64] <= s_axis.tdata;
          wdog   <= 16'd0;
          rx_cnt <= rx_cnt + 3'd1;
          if (s_axis.tlast || &rx_cnt) begin
            o_err_tlast <= s_axis.tlast != (&rx_cnt);
            state       <= DONE;
          end
        end else if (wdog == 16'(TIMEOUT_CYCLES - 1)) begin
          o_err_timeout <= 1'b1;
          state         <= DONE;
        end else wdog <= wdog + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
